// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single data-memory port between two requesters:
//   port 0 = CPU load/store path, port 1 = IO/DMA path. Accesses are
//   serialised with a req/ack handshake; ties are resolved round-robin
//   (FIXED_PR=0) or always in favour of port 0 (FIXED_PR=1). This block
//   owns every Memory control strobe.
//
// Parameters
//   RD_LAT    cycles dm_cs/dm_rd are held before dm_out is captured (1..15)
//   FIXED_PR  0 = round-robin on tie, 1 = port 0 always wins a tie
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   req0/wr0/addr0/wdata0       port 0 request, direction, address, write data
//   rdata0/ack0                 port 0 read data and one-cycle completion pulse
//   req1/wr1/addr1/wdata1       port 1 request, direction, address, write data
//   rdata1/ack1                 port 1 read data and one-cycle completion pulse
//   busy                        high whenever a transaction is in flight
//   gnt                         owner of the current transaction
//   dm_cs/dm_rd/dm_wr           memory chip select, read and write strobes
//   dm_address/dm_d_in          memory address and write data
//   dm_out                      memory read data

module dmem_arbiter #(
    parameter int unsigned RD_LAT   = 1,
    parameter bit          FIXED_PR = 1'b0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0,
    input  logic        wr0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic [31:0] rdata0,
    output logic        ack0,

    input  logic        req1,
    input  logic        wr1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic [31:0] rdata1,
    output logic        ack1,

    output logic        busy,
    output logic        gnt,

    output logic        dm_cs,
    output logic        dm_rd,
    output logic        dm_wr,
    output logic [31:0] dm_address,
    output logic [31:0] dm_d_in,
    input  logic [31:0] dm_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(RD_LAT);

    state_t      state;
    logic [3:0]  cnt;        // ACCESS cycles remaining, including the current one
    logic        last;       // owner of the most recently completed transaction
    logic        winner;
    logic        sel_wr;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    // Arbitration on the live request lines; only consulted in IDLE.
    always_comb begin
        if (req0 && req1) begin
            winner = FIXED_PR ? 1'b0 : ~last;
        end else begin
            winner = req1;
        end
        sel_wr    = winner ? wr1    : wr0;
        sel_addr  = winner ? addr1  : addr0;
        sel_wdata = winner ? wdata1 : wdata0;
    end

    // Address and write data are registered at grant time; the requester
    // keeps them stable until ack, so this matches driving them from the
    // live inputs during ACCESS while keeping every memory strobe glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last       <= 1'b1;
            gnt        <= 1'b0;
            busy       <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            dm_cs      <= 1'b0;
            dm_rd      <= 1'b0;
            dm_wr      <= 1'b0;
            dm_address <= '0;
            dm_d_in    <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state      <= ACCESS;
                        gnt        <= winner;
                        busy       <= 1'b1;
                        dm_cs      <= 1'b1;
                        dm_rd      <= ~sel_wr;
                        dm_wr      <= sel_wr;
                        dm_address <= sel_addr;
                        dm_d_in    <= sel_wr ? sel_wdata : '0;
                        // Writes always take a single ACCESS cycle.
                        cnt        <= sel_wr ? 4'd1 : LAT;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd1) begin
                        if (dm_rd) begin
                            if (gnt) begin
                                rdata1 <= dm_out;
                            end else begin
                                rdata0 <= dm_out;
                            end
                        end
                        if (gnt) begin
                            ack1 <= 1'b1;
                        end else begin
                            ack0 <= 1'b1;
                        end
                        dm_cs      <= 1'b0;
                        dm_rd      <= 1'b0;
                        dm_wr      <= 1'b0;
                        dm_address <= '0;
                        dm_d_in    <= '0;
                        state      <= ACK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    last  <= gnt;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    dm_cs      <= 1'b0;
                    dm_rd      <= 1'b0;
                    dm_wr      <= 1'b0;
                    dm_address <= '0;
                    dm_d_in    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Two arbiters side by side: A (RD_LAT=1, round-robin) and B (RD_LAT=3,
//   port 0 priority), each with its own word memory. A transaction-level
//   model predicts every output for every cycle from the latency and
//   arbitration rules; directed steps add checks on latency, ordering and
//   reset abort, followed by a randomized traffic phase.

module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [2];
    logic        req0   [2];
    logic        wr0    [2];
    logic [31:0] addr0  [2];
    logic [31:0] wdata0 [2];
    logic [31:0] rdata0 [2];
    logic        ack0   [2];
    logic        req1   [2];
    logic        wr1    [2];
    logic [31:0] addr1  [2];
    logic [31:0] wdata1 [2];
    logic [31:0] rdata1 [2];
    logic        ack1   [2];
    logic        busy   [2];
    logic        gnt    [2];
    logic        dm_cs  [2];
    logic        dm_rd  [2];
    logic        dm_wr  [2];
    logic [31:0] dm_address [2];
    logic [31:0] dm_d_in    [2];
    logic [31:0] dm_out     [2];

    dmem_arbiter #(.RD_LAT(1), .FIXED_PR(1'b0)) dut_a (
        .clk(clk), .reset(rst[0]),
        .req0(req0[0]), .wr0(wr0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]),
        .rdata0(rdata0[0]), .ack0(ack0[0]),
        .req1(req1[0]), .wr1(wr1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]),
        .rdata1(rdata1[0]), .ack1(ack1[0]),
        .busy(busy[0]), .gnt(gnt[0]),
        .dm_cs(dm_cs[0]), .dm_rd(dm_rd[0]), .dm_wr(dm_wr[0]),
        .dm_address(dm_address[0]), .dm_d_in(dm_d_in[0]), .dm_out(dm_out[0])
    );

    dmem_arbiter #(.RD_LAT(3), .FIXED_PR(1'b1)) dut_b (
        .clk(clk), .reset(rst[1]),
        .req0(req0[1]), .wr0(wr0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]),
        .rdata0(rdata0[1]), .ack0(ack0[1]),
        .req1(req1[1]), .wr1(wr1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]),
        .rdata1(rdata1[1]), .ack1(ack1[1]),
        .busy(busy[1]), .gnt(gnt[1]),
        .dm_cs(dm_cs[1]), .dm_rd(dm_rd[1]), .dm_wr(dm_wr[1]),
        .dm_address(dm_address[1]), .dm_d_in(dm_d_in[1]), .dm_out(dm_out[1])
    );

    // Behavioural word memories (256 words each, byte address bits [9:2]).
    logic [31:0] mem [2][256];
    logic        mem_clr;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_clr) begin
                for (int i = 0; i < 256; i++) mem[d][i] <= '0;
            end else if (dm_cs[d] && dm_wr[d]) begin
                mem[d][dm_address[d][9:2]] <= dm_d_in[d];
            end
        end
    end

    assign dm_out[0] = mem[0][dm_address[0][9:2]];
    assign dm_out[1] = mem[1][dm_address[1][9:2]];

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;

    typedef struct {
        int          d;
        int          p;
        int unsigned c;
    } ev_t;

    op_t         oq [4][$];          // pending ops, index d*2+port
    ev_t         alog [$];           // observed acks
    bit          mb     [2];         // transaction in flight
    int unsigned mstart [2];         // IDLE cycle in which it was granted
    int unsigned mlat   [2];         // number of ACCESS cycles
    bit          mown   [2];
    bit          mlast  [2];
    bit          mwr    [2];
    logic [31:0] maddr  [2];
    logic [31:0] mwdata [2];
    logic [31:0] mrval  [2];
    logic [31:0] shadow [2][256];
    logic [31:0] exp_rd [2][2];
    bit          rst_pend [2];
    bit          in_rst   [2];

    int unsigned cyc;
    int unsigned n_pass, n_fail, n_total;
    int unsigned gap_pct;

    function automatic int unsigned lat_of(input int d);
        return (d == 1) ? 32'd3 : 32'd1;
    endfunction

    function automatic bit fixed_of(input int d);
        return d == 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive_port(input int d, input int p, input bit rq, input op_t op);
        if (p == 1) begin
            req1[d] = rq; wr1[d] = op.wr; addr1[d] = op.addr; wdata1[d] = op.wdata;
        end else begin
            req0[d] = rq; wr0[d] = op.wr; addr0[d] = op.addr; wdata0[d] = op.wdata;
        end
    endtask

    function automatic bit req_of(input int d, input int p);
        return (p == 1) ? req1[d] : req0[d];
    endfunction

    task automatic model_cycle(input int d);
        string       pf;
        bit          was_idle, acked, w, r0, r1;
        logic        e_busy, e_cs, e_rd, e_wr, e_ack0, e_ack1;
        logic [31:0] e_addr, e_din;
        int unsigned k;
        op_t         op;
        pf = (d == 1) ? "B" : "A";
        e_busy = 0; e_cs = 0; e_rd = 0; e_wr = 0; e_ack0 = 0; e_ack1 = 0;
        e_addr = '0; e_din = '0;
        was_idle = !mb[d];
        acked = 0;
        if (mb[d]) begin
            k = cyc - mstart[d];
            e_busy = 1;
            if (k <= mlat[d]) begin
                e_cs = 1; e_rd = !mwr[d]; e_wr = mwr[d];
                e_addr = maddr[d];
                e_din = mwr[d] ? mwdata[d] : 32'h0;
            end else begin
                acked = 1;
                if (!mwr[d]) exp_rd[d][mown[d]] = mrval[d];
                if (mown[d]) e_ack1 = 1; else e_ack0 = 1;
            end
            chk({pf, "_gnt"}, 32'(gnt[d]), 32'(mown[d]));
        end
        if (in_rst[d]) chk({pf, "_gnt_reset"}, 32'(gnt[d]), 32'h0);
        chk({pf, "_busy"},    32'(busy[d]),  32'(e_busy));
        chk({pf, "_dm_cs"},   32'(dm_cs[d]), 32'(e_cs));
        chk({pf, "_dm_rd"},   32'(dm_rd[d]), 32'(e_rd));
        chk({pf, "_dm_wr"},   32'(dm_wr[d]), 32'(e_wr));
        chk({pf, "_dm_addr"}, dm_address[d], e_addr);
        chk({pf, "_dm_din"},  dm_d_in[d],    e_din);
        chk({pf, "_ack0"},    32'(ack0[d]),  32'(e_ack0));
        chk({pf, "_ack1"},    32'(ack1[d]),  32'(e_ack1));
        chk({pf, "_rdata0"},  rdata0[d],     exp_rd[d][0]);
        chk({pf, "_rdata1"},  rdata1[d],     exp_rd[d][1]);
        if (ack0[d] === 1'b1) alog.push_back('{d, 0, cyc});
        if (ack1[d] === 1'b1) alog.push_back('{d, 1, cyc});

        // requester side: drop req on ack, then possibly issue the next op
        if (acked) begin
            void'(oq[d*2 + int'(mown[d])].pop_front());
            drive_port(d, int'(mown[d]), 1'b0, '0);
            mb[d] = 0;
            mlast[d] = mown[d];
        end
        if (in_rst[d]) begin
            rst[d] = 1'b0;
            in_rst[d] = 0;
        end
        if (rst_pend[d]) begin
            rst[d] = 1'b1;
            rst_pend[d] = 0;
            in_rst[d] = 1;
            mb[d] = 0;
            mlast[d] = 1;
            exp_rd[d][0] = '0;
            exp_rd[d][1] = '0;
            for (int p = 0; p < 2; p++) begin
                oq[d*2 + p].delete();
                drive_port(d, p, 1'b0, '0);
            end
            return;
        end
        for (int p = 0; p < 2; p++) begin
            if (!req_of(d, p) && oq[d*2 + p].size() > 0 && $urandom_range(99) >= gap_pct) begin
                op = oq[d*2 + p][0];
                drive_port(d, p, 1'b1, op);
            end
        end

        // arbiter side: an idle arbiter takes a request seen at this cycle's end
        r0 = req0[d];
        r1 = req1[d];
        if (was_idle && (r0 || r1)) begin
            if (r0 && r1) w = fixed_of(d) ? 1'b0 : !mlast[d];
            else          w = r1;
            mb[d] = 1;
            mstart[d] = cyc;
            mown[d] = w;
            mwr[d]    = w ? wr1[d]    : wr0[d];
            maddr[d]  = w ? addr1[d]  : addr0[d];
            mwdata[d] = w ? wdata1[d] : wdata0[d];
            mlat[d] = mwr[d] ? 32'd1 : lat_of(d);
            if (mwr[d]) shadow[d][maddr[d][9:2]] = mwdata[d];
            else        mrval[d] = shadow[d][maddr[d][9:2]];
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) model_cycle(d);
    endtask

    function automatic bit all_idle();
        for (int d = 0; d < 2; d++) begin
            if (mb[d] || rst_pend[d] || in_rst[d]) return 0;
            for (int p = 0; p < 2; p++) if (oq[d*2 + p].size() != 0) return 0;
        end
        return 1;
    endfunction

    task automatic run_idle(input int unsigned max_cycles, input string tag);
        int unsigned n;
        n = 0;
        while (!all_idle() && n < max_cycles) begin
            step();
            n++;
        end
        if (!all_idle()) begin
            n_total++;
            n_fail++;
            $error("FAIL %s_timeout: still busy after %0d cycles, required idle", tag, n);
        end
    endtask

    function automatic op_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        op_t o;
        o.wr = wr; o.addr = addr; o.wdata = wr ? data : 32'h0;
        return o;
    endfunction

    function automatic op_t rnd_op();
        logic [7:0] a;
        a = 8'($urandom);
        return mk(1'($urandom), {22'h0, a, 2'b00}, $urandom);
    endfunction

    // ports and ack cycles of DUT d, in ack order
    task automatic acks_of(input int d, output int ps [$], output int unsigned cs [$]);
        ps.delete();
        cs.delete();
        foreach (alog[i]) if (alog[i].d == d) begin
            ps.push_back(alog[i].p);
            cs.push_back(alog[i].c);
        end
    endtask

    initial begin
        int          ps [$];
        int unsigned cs [$];
        int unsigned r0;

        n_pass = 0; n_fail = 0; n_total = 0; cyc = 0; gap_pct = 0;
        mem_clr = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            drive_port(d, 0, 1'b0, '0);
            drive_port(d, 1, 1'b0, '0);
            mb[d] = 0; mlast[d] = 1; rst_pend[d] = 1; in_rst[d] = 1;
            exp_rd[d][0] = '0; exp_rd[d][1] = '0;
            for (int i = 0; i < 256; i++) shadow[d][i] = '0;
        end
        step();
        mem_clr = 1'b0;
        step();

        // 1. preload 0x10 through port 1, then port 0 read: ack two cycles later
        oq[1].push_back(mk(1, 32'h10, 32'hDEADBEEF));
        run_idle(20, "t1w");
        alog.delete();
        r0 = cyc + 1;
        oq[0].push_back(mk(0, 32'h10, 32'h0));
        run_idle(20, "t1r");
        acks_of(0, ps, cs);
        chk("t1_ack_count", 32'(ps.size()), 32'd1);
        if (ps.size() == 1) chk("t1_ack_latency", cs[0] - r0, 32'd2);
        chk("t1_rdata0", rdata0[0], 32'hDEADBEEF);

        // 2. port 1 write then port 0 read-back
        alog.delete();
        r0 = cyc + 1;
        oq[1].push_back(mk(1, 32'h20, 32'h12345678));
        run_idle(20, "t2w");
        acks_of(0, ps, cs);
        chk("t2_wr_ack_count", 32'(ps.size()), 32'd1);
        if (ps.size() == 1) chk("t2_wr_ack_latency", cs[0] - r0, 32'd2);
        oq[0].push_back(mk(0, 32'h20, 32'h0));
        run_idle(20, "t2r");
        chk("t2_rdata0", rdata0[0], 32'h12345678);
        chk("t2_rdata1_untouched", rdata1[0], 32'h0);

        // 3. round robin after reset: both hold reads, acks alternate every 3 cycles
        rst_pend[0] = 1;
        step();
        step();
        alog.delete();
        for (int i = 0; i < 4; i++) begin
            oq[0].push_back(mk(0, 32'h10, 32'h0));
            oq[1].push_back(mk(0, 32'h20, 32'h0));
        end
        run_idle(60, "t3");
        acks_of(0, ps, cs);
        chk("t3_ack_count", 32'(ps.size()), 32'd8);
        foreach (ps[i]) begin
            chk("t3_order", 32'(ps[i]), 32'(i % 2));
            if (i > 0) chk("t3_spacing", cs[i] - cs[i-1], 32'd3);
        end

        // 4. fixed priority: port 0 keeps winning while it holds req
        alog.delete();
        oq[2].push_back(mk(0, 32'h40, 32'h0));
        oq[2].push_back(mk(0, 32'h44, 32'h0));
        oq[3].push_back(mk(0, 32'h48, 32'h0));
        run_idle(60, "t4");
        acks_of(1, ps, cs);
        chk("t4_ack_count", 32'(ps.size()), 32'd3);
        if (ps.size() == 3) begin
            chk("t4_first",  32'(ps[0]), 32'd0);
            chk("t4_second", 32'(ps[1]), 32'd0);
            chk("t4_third",  32'(ps[2]), 32'd1);
        end

        // 5. reset during the 2nd ACCESS cycle of an RD_LAT=3 read aborts it
        oq[3].push_back(mk(1, 32'h80, 32'hCAFEF00D));
        run_idle(20, "t5w");
        alog.delete();
        oq[2].push_back(mk(0, 32'h80, 32'h0));
        step();                      // IDLE cycle 0, request granted
        step();                      // ACCESS 1
        rst_pend[1] = 1;
        step();                      // ACCESS 2, reset sampled at its end
        step();
        chk("t5_cs_after_reset",   32'(dm_cs[1]), 32'h0);
        chk("t5_busy_after_reset", 32'(busy[1]),  32'h0);
        acks_of(1, ps, cs);
        chk("t5_no_ack", 32'(ps.size()), 32'd0);
        r0 = cyc + 1;
        oq[2].push_back(mk(0, 32'h80, 32'h0));
        run_idle(20, "t5r");
        acks_of(1, ps, cs);
        chk("t5_ack_count", 32'(ps.size()), 32'd1);
        if (ps.size() == 1) chk("t5_ack_latency", cs[0] - r0, 32'd4);
        chk("t5_rdata0", rdata0[1], 32'hCAFEF00D);

        // randomized traffic on both arbiters with random request gaps
        gap_pct = 40;
        for (int n = 0; n < 600; n++) begin
            for (int q = 0; q < 4; q++) begin
                if (oq[q].size() < 2 && $urandom_range(99) < 25) oq[q].push_back(rnd_op());
            end
            if (n == 300) rst_pend[$urandom_range(1)] = 1;
            step();
        end
        run_idle(300, "rand");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
